// File: rtl/btn_pkg.sv
// btn_pkg: shared FSM state encoding and counter-width helper for the button front-end
package btn_pkg;
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer, async active-low reset to 0
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] ff_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ff_q <= '0;
    else        ff_q <= {ff_q[0], d_i};
  assign q_o = ff_q[1];
endmodule

// File: rtl/btn_debounce_pulse.sv
// btn_debounce_pulse: debounces a raw button into a clean level and one-cycle count-enable pulses.
// Optional auto-repeat while held is built when BTN_REPEAT_EN is defined.
module btn_debounce_pulse
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYC  = 500000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic en_out,
  output logic btn_level,
  output logic busy
);
  localparam int CW = cnt_w(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);
  btn_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic s, press_fire, rpt_fire, pulse_q, en_q, lvl_q;
  sync_2ff u_sync (.clk(clk), .rst_n(rst_n), .d_i(btn_in), .q_o(s));
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:         if (s) state_d = PRESS_WAIT;
      PRESS_WAIT:   state_d = !s ? IDLE : (cnt_q == CNT_LAST) ? HELD : PRESS_WAIT;
      HELD:         if (!s) state_d = RELEASE_WAIT;
      RELEASE_WAIT: state_d = s ? HELD : (cnt_q == CNT_LAST) ? IDLE : RELEASE_WAIT;
    endcase
    press_fire = state_q == PRESS_WAIT && state_d == HELD;
    // Counter restarts on every state change and saturates rather than wrapping
    cnt_d = state_d != state_q ? '0 : (cnt_q == CNT_LAST) ? cnt_q : cnt_q + 1'b1;
  end
`ifdef BTN_REPEAT_EN
  localparam int RW = cnt_w(REPEAT_DELAY);
  logic [RW-1:0] rpt_q, rpt_d;
  always_comb begin
    rpt_fire = state_q == HELD && state_d == HELD && rpt_q == RW'(REPEAT_DELAY - 1);
    // After a repeat, rewind so the next one lands REPEAT_PERIOD cycles later
    rpt_d = (state_q != HELD || state_d != HELD) ? '0
          : rpt_fire ? RW'(REPEAT_DELAY - REPEAT_PERIOD) : rpt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rpt_q <= '0;
    else        rpt_q <= rpt_d;
`else
  assign rpt_fire = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      en_q    <= 1'b0;
      lvl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= press_fire | rpt_fire;
      en_q    <= pulse_q;
      lvl_q   <= state_q == HELD || state_q == RELEASE_WAIT;
    end
  assign en_out    = en_q;
  assign btn_level = lvl_q;
  assign busy      = state_q == PRESS_WAIT || state_q == RELEASE_WAIT;
endmodule

// File: tb/tb_btn_debounce_pulse.sv
// tb_btn_debounce_pulse: scoreboard bench for the debouncer (DEBOUNCE_CYC=4, REPEAT_DELAY=20, REPEAT_PERIOD=8)
module tb_btn_debounce_pulse;
  logic clk = 1'b0, rst_n = 1'b0, btn_in = 1'b0;
  logic en_out, btn_level, busy;
  int nvec = 0, nerr = 0;
  int exp_q[$];
  always #5 clk = ~clk;
  btn_debounce_pulse #(.DEBOUNCE_CYC(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
    .en_out(en_out), .btn_level(btn_level), .busy(busy)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_btn(input int n);
    btn_in = 1'b0;
    repeat (n) tick();
  endtask
  task automatic test_reset();
    logic exp_en;
    rst_n = 1'b0;
    btn_in = 1'b1;
    repeat (3) tick();
    nvec++; if (en_out !== 1'b0) begin nerr++; $display("FAIL reset en_out: got %b want 0", en_out); end
    nvec++; if (btn_level !== 1'b0) begin nerr++; $display("FAIL reset btn_level: got %b want 0", btn_level); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset busy: got %b want 0", busy); end
    rst_n = 1'b1;
    exp_q.push_back(7);
    for (int e = 0; e < 12; e++) begin
      tick();
      exp_en = exp_q.size() > 0 && exp_q[0] == e;
      nvec++; if (en_out !== exp_en) begin nerr++; $display("FAIL reset_release en_out edge %0d: got %b want %b", e, en_out, exp_en); end
      if (exp_en) void'(exp_q.pop_front());
    end
    idle_btn(12);
  endtask
  task automatic test_clean_press();
    logic exp_en;
    btn_in = 1'b1;
    exp_q.push_back(7);
    for (int e = 0; e < 30; e++) begin
      tick();
      exp_en = exp_q.size() > 0 && exp_q[0] == e;
      nvec++; if (en_out !== exp_en) begin nerr++; $display("FAIL press en_out edge %0d: got %b want %b", e, en_out, exp_en); end
      if (exp_en) void'(exp_q.pop_front());
      nvec++; if (btn_level !== (e >= 7)) begin nerr++; $display("FAIL press btn_level edge %0d: got %b want %b", e, btn_level, e >= 7); end
      nvec++; if (busy !== (e >= 2 && e <= 5)) begin nerr++; $display("FAIL press busy edge %0d: got %b want %b", e, busy, e >= 2 && e <= 5); end
    end
    btn_in = 1'b0;
    for (int e = 0; e < 12; e++) begin
      tick();
      nvec++; if (en_out !== 1'b0) begin nerr++; $display("FAIL release en_out edge %0d: got %b want 0", e, en_out); end
      nvec++; if (btn_level !== (e < 7)) begin nerr++; $display("FAIL release btn_level edge %0d: got %b want %b", e, btn_level, e < 7); end
      nvec++; if (busy !== (e >= 2 && e <= 5)) begin nerr++; $display("FAIL release busy edge %0d: got %b want %b", e, busy, e >= 2 && e <= 5); end
    end
  endtask
  task automatic test_bounce();
    logic exp_en;
    exp_q.push_back(15);
    for (int e = 0; e < 24; e++) begin
      btn_in = e >= 8 || (e % 4) < 2;
      tick();
      exp_en = exp_q.size() > 0 && exp_q[0] == e;
      nvec++; if (en_out !== exp_en) begin nerr++; $display("FAIL bounce en_out edge %0d: got %b want %b", e, en_out, exp_en); end
      if (exp_en) void'(exp_q.pop_front());
      nvec++; if (btn_level !== (e >= 15)) begin nerr++; $display("FAIL bounce btn_level edge %0d: got %b want %b", e, btn_level, e >= 15); end
    end
    idle_btn(12);
  endtask
  task automatic test_release_bounce();
    logic exp_en;
    btn_in = 1'b1;
    exp_q.push_back(7);
    for (int e = 0; e < 12; e++) begin
      tick();
      exp_en = exp_q.size() > 0 && exp_q[0] == e;
      nvec++; if (en_out !== exp_en) begin nerr++; $display("FAIL relbounce_press en_out edge %0d: got %b want %b", e, en_out, exp_en); end
      if (exp_en) void'(exp_q.pop_front());
    end
    for (int e = 0; e < 20; e++) begin
      btn_in = e >= 2;
      tick();
      nvec++; if (en_out !== 1'b0) begin nerr++; $display("FAIL relbounce en_out edge %0d: got %b want 0", e, en_out); end
      nvec++; if (btn_level !== 1'b1) begin nerr++; $display("FAIL relbounce btn_level edge %0d: got %b want 1", e, btn_level); end
    end
    idle_btn(12);
  endtask
  task automatic test_reset_mid_press();
    logic exp_en;
    btn_in = 1'b1;
    repeat (6) tick();
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL midreset busy_before: got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    nvec++; if (en_out !== 1'b0) begin nerr++; $display("FAIL midreset en_out: got %b want 0", en_out); end
    nvec++; if (btn_level !== 1'b0) begin nerr++; $display("FAIL midreset btn_level: got %b want 0", btn_level); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL midreset busy: got %b want 0", busy); end
    btn_in = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick();
      nvec++; if (en_out !== 1'b0) begin nerr++; $display("FAIL midreset_after en_out edge %0d: got %b want 0", e, en_out); end
    end
    btn_in = 1'b1;
    exp_q.push_back(7);
    for (int e = 0; e < 12; e++) begin
      tick();
      exp_en = exp_q.size() > 0 && exp_q[0] == e;
      nvec++; if (en_out !== exp_en) begin nerr++; $display("FAIL midreset_repress en_out edge %0d: got %b want %b", e, en_out, exp_en); end
      if (exp_en) void'(exp_q.pop_front());
      nvec++; if (btn_level !== (e >= 7)) begin nerr++; $display("FAIL midreset_repress btn_level edge %0d: got %b want %b", e, btn_level, e >= 7); end
    end
    idle_btn(12);
  endtask
  task automatic test_repeat();
    logic exp_en;
`ifdef BTN_REPEAT_EN
    exp_q = '{7, 27, 35, 43, 51, 59};
`else
    exp_q = '{7};
`endif
    btn_in = 1'b1;
    for (int e = 0; e < 60; e++) begin
      tick();
      exp_en = exp_q.size() > 0 && exp_q[0] == e;
      nvec++; if (en_out !== exp_en) begin nerr++; $display("FAIL repeat en_out edge %0d: got %b want %b", e, en_out, exp_en); end
      if (exp_en) void'(exp_q.pop_front());
    end
    btn_in = 1'b0;
    for (int e = 0; e < 12; e++) begin
      tick();
      nvec++; if (en_out !== 1'b0) begin nerr++; $display("FAIL repeat_release en_out edge %0d: got %b want 0", e, en_out); end
    end
    nvec++; if (exp_q.size() != 0) begin nerr++; $display("FAIL repeat pending pulses: got %0d want 0", exp_q.size()); end
    exp_q.delete();
  endtask
  task automatic test_counter_chain();
    logic [7:0] cnt8 = 8'd0;
    for (int p = 0; p < 5; p++) begin
      btn_in = 1'b1;
      repeat (12) begin tick(); if (en_out) cnt8++; end
      btn_in = 1'b0;
      repeat (12) begin tick(); if (en_out) cnt8++; end
    end
    nvec++; if (cnt8 !== 8'd5) begin nerr++; $display("FAIL counter_chain count: got %0d want 5", cnt8); end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_bounce();
    test_reset_mid_press();
    test_repeat();
    test_counter_chain();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
